// File: rtl/sigan_disp_pkg.sv
// Shared constants and types for the signature-analyzer display scan
// controller: digit geometry, the HP-hex segment patterns and the
// per-slot state enum.
package sigan_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int NIB_W      = 4;
    localparam int SIG_W      = 16;
    localparam int IDX_W      = 2;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active high.
    // The HP character set shows the upper six codes as A,C,F,H,P,U.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;  // A
    localparam logic [SEG_W-1:0] SEG_B = 7'h39;  // shown as C
    localparam logic [SEG_W-1:0] SEG_C = 7'h71;  // shown as F
    localparam logic [SEG_W-1:0] SEG_D = 7'h76;  // shown as H
    localparam logic [SEG_W-1:0] SEG_E = 7'h73;  // shown as P
    localparam logic [SEG_W-1:0] SEG_F = 7'h3E;  // shown as U

    // Phase within one digit slot: blanked lead-in, then driven.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_e;

    // One-hot digit enable for a digit index (bit 3 is the leftmost digit).
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
        return NUM_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/hp_hex_decode.sv
// Combinational HP-hex character decoder: one nibble in, seven active-high
// segments {g,f,e,d,c,b,a} out. A single instance is time-shared across
// all display digits.
module hp_hex_decode
    import sigan_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    // Nibble to segment pattern lookup.
    always_comb begin
        // NOTE: seg_o gets a default before the case so no path can leave it
        // unassigned; that is what keeps this block from inferring a latch.
        seg_o = '0;
        unique case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = '0;
        endcase
    end

endmodule

// File: rtl/sig_display.sv
// Display scan controller for the signature analyzer.
// Captures each accepted 16-bit signature into a shadow register, transfers
// it to the display register only at the end of a full scan frame, and
// multiplexes four digits (most significant nibble leftmost) through one
// shared HP-hex decoder. Each digit slot starts with a blanked interval to
// suppress ghosting.
// Optional feature: define SIGAN_UNSTABLE_EN to build the previous-signature
// register and comparator that drive 'unstable'; otherwise 'unstable' is 0.
module sig_display
    import sigan_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 1024,  // cycles per digit slot, 4..65535
    parameter int BLANK_CYCLES = 16     // blanked cycles per slot, < SCAN_DIV
) (
    input  logic                  clock,
    input  logic                  reset_l,
    input  logic                  sig_valid,
    input  logic [SIG_W-1:0]      signature,
    input  logic                  hold,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [SEG_W-1:0]      seg,
    output logic                  unstable
);

    localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Scan position: slot counter and digit index.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Signature path: shadow catches strobes, display is what gets scanned.
    logic [SIG_W-1:0]      shadow_q, shadow_d;
    logic [SIG_W-1:0]      disp_q, disp_d;
    logic                  measured_q, measured_d;

    // Registered outputs.
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic [SEG_W-1:0]      seg_q, seg_d;

    // Decoded slot phase and scan boundaries.
    slot_state_e           slot_state;
    logic                  slot_end;
    logic                  frame_end;
    logic                  accept;

    // Shared decoder input/output.
    logic [NIB_W-1:0]      cur_nibble;
    logic [SEG_W-1:0]      dec_seg;

    assign accept    = sig_valid & ~hold;
    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Nibble of the display word belonging to the digit currently scanned.
    assign cur_nibble = disp_q[{idx_q, 2'b00} +: NIB_W];

    hp_hex_decode u_decode (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

    // Slot FSM decode: the slot counter is the state register, and its
    // position within the slot selects BLANK or DRIVE.
    always_comb begin
        slot_state = DRIVE;
        if (cnt_q < BLANK_END) begin
            slot_state = BLANK;
        end
    end

    // Next scan position: counter wraps each slot, index advances on the wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Next signature state: accept strobes into shadow, move shadow into the
    // display only at a frame boundary so one frame never mixes two values.
    always_comb begin
        shadow_d   = shadow_q;
        measured_d = measured_q;
        disp_d     = disp_q;
        if (accept) begin
            shadow_d   = signature;
            measured_d = 1'b1;
        end
        if (frame_end && !hold) begin
            disp_d = shadow_q;
        end
    end

    // Next outputs from the current slot phase: blanked, or one digit driven
    // with its decoded nibble (segments stay dark until a first measurement).
    always_comb begin
        digit_en_d = '0;
        seg_d      = '0;
        unique case (slot_state)
            BLANK: begin
                digit_en_d = '0;
                seg_d      = '0;
            end
            DRIVE: begin
                digit_en_d = digit_onehot(idx_q);
                if (measured_q) begin
                    seg_d = dec_seg;
                end
            end
            default: begin
                digit_en_d = '0;
                seg_d      = '0;
            end
        endcase
    end

    // Scan position registers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of block order.
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Signature capture and display registers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            shadow_q   <= '0;
            disp_q     <= '0;
            measured_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            measured_q <= measured_d;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            digit_en_q <= '0;
            seg_q      <= '0;
        end else begin
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign digit_en = digit_en_q;
    assign seg      = seg_q;

`ifdef SIGAN_UNSTABLE_EN
    logic [SIG_W-1:0] prev_q, prev_d;
    logic             unstable_q, unstable_d;

    // Stability compare: each accepted strobe after the first is compared
    // with the one before it; the first one only primes the history.
    always_comb begin
        prev_d     = prev_q;
        unstable_d = unstable_q;
        if (accept) begin
            prev_d = signature;
            if (measured_q) begin
                unstable_d = (signature != prev_q);
            end
        end
    end

    // Previous-signature and unstable flag registers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            prev_q     <= '0;
            unstable_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = 1'b0;
`endif

endmodule
